// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller at the ID/EX boundary: load-use and memory-wait hazards,
// branch redirect squash, memory wait timeout and stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic             id_valid,
  input  logic [31:0]      ex_inst,
  input  logic             ex_valid,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  localparam logic [7:0] TO_M1 = 8'(MEM_TIMEOUT - 1);

  state_e           state_q;
  logic [7:0]       wcnt_q;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic [6:0] id_op;
  logic       rs1_use, rs2_use, lu, mw;

  assign id_op = id_inst[6:0];

  always_comb begin
    rs1_use = id_op inside {7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011,
                            7'b1100011, 7'b0100011, 7'b0000011, 7'b1100111};
    rs2_use = id_op inside {7'b0110011, 7'b0111011, 7'b1100011, 7'b0100011};
  end

  assign lu = ex_valid && (ex_inst[6:0] == 7'b0000011) && (ex_inst[11:7] != 5'd0) &&
              id_valid && ((rs1_use && (id_inst[19:15] == ex_inst[11:7])) ||
                           (rs2_use && (id_inst[24:20] == ex_inst[11:7])));
  assign mw = mem_req && !mem_ack;

  // A frozen EX keeps any redirect/load-use alive, so mw simply outranks them.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mw) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: if (mw) begin
          state_q <= MEM_WAIT;
          wcnt_q  <= 8'd1;
        end
        MEM_WAIT: begin
          if (mem_req && mem_ack) begin
            state_q <= RUN;
            wcnt_q  <= '0;
          end else if (mw) begin
            if (wcnt_q < 8'(MEM_TIMEOUT)) wcnt_q <= wcnt_q + 8'd1;
            if (wcnt_q >= TO_M1) timeout_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
      if (pc_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((ifid_flush || idex_flush) && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{ex_inst[31:12], id_inst[14:7], id_inst[31:25]};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for the control decode plus
// hand sequences for memory wait, deferral, timeout, reset and saturation.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_inst, ex_inst;
  logic        id_valid, ex_valid, ex_redirect, mem_req, mem_ack;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic        exmem_stall, memwb_flush, mem_timeout;
  logic [3:0]  stall_cnt, flush_cnt;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
    .ex_inst(ex_inst), .ex_valid(ex_valid), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_stall(idex_stall),
    .idex_flush(idex_flush), .exmem_stall(exmem_stall), .memwb_flush(memwb_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_MW   = 7'b1101011;
  localparam logic [6:0] C_FL   = 7'b0010100;

  localparam logic [31:0] LW5    = 32'h0002A283;
  localparam logic [31:0] LW0    = 32'h0002A003;
  localparam logic [31:0] ADD_R1 = 32'h00128333; // add x6,x5,x1
  localparam logic [31:0] ADD_R2 = 32'h00508333; // add x6,x1,x5
  localparam logic [31:0] SW_R2  = 32'h00512023; // sw x5,0(x2)
  localparam logic [31:0] BEQ_R2 = 32'h00508063; // beq x1,x5
  localparam logic [31:0] ADDIW  = 32'h0012831B; // addiw x6,x5,1
  localparam logic [31:0] JALR   = 32'h000280E7; // jalr x1,0(x5)
  localparam logic [31:0] LUI    = 32'h0002A2B7; // lui x5 with field[19:15]=5
  localparam logic [31:0] JAL    = 32'h0002A2EF; // jal x5 with field[19:15]=5
  localparam logic [31:0] ADDI_I = 32'h00508313; // addi x6,x1,5 (imm in rs2 field)
  localparam logic [31:0] ADDI0  = 32'h00100393; // addi x7,x0,1
  localparam logic [31:0] ADD_EX = 32'h005002B3; // add x5,x0,x5

  typedef struct {
    string       nm;
    logic [31:0] idi;
    logic        idv;
    logic [31:0] exi;
    logic        exv, rd, rq, ak;
    logic [6:0]  exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [6:0] ctl();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] idi, input logic idv, input logic [31:0] exi,
                       input logic exv, input logic rd, input logic rq, input logic ak);
    id_inst = idi; id_valid = idv; ex_inst = exi; ex_valid = exv;
    ex_redirect = rd; mem_req = rq; mem_ack = ak;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tbl.push_back('{"lu_rs1",     ADD_R1, 1, LW5,    1, 0, 0, 0, C_LU});
    tbl.push_back('{"lu_rs2",     ADD_R2, 1, LW5,    1, 0, 0, 0, C_LU});
    tbl.push_back('{"lu_store",   SW_R2,  1, LW5,    1, 0, 0, 0, C_LU});
    tbl.push_back('{"lu_branch",  BEQ_R2, 1, LW5,    1, 0, 0, 0, C_LU});
    tbl.push_back('{"lu_addiw",   ADDIW,  1, LW5,    1, 0, 0, 0, C_LU});
    tbl.push_back('{"lu_jalr",    JALR,   1, LW5,    1, 0, 0, 0, C_LU});
    tbl.push_back('{"no_lui",     LUI,    1, LW5,    1, 0, 0, 0, C_NONE});
    tbl.push_back('{"no_jal",     JAL,    1, LW5,    1, 0, 0, 0, C_NONE});
    tbl.push_back('{"no_imm_rs2", ADDI_I, 1, LW5,    1, 0, 0, 0, C_NONE});
    tbl.push_back('{"no_rd0",     ADDI0,  1, LW0,    1, 0, 0, 0, C_NONE});
    tbl.push_back('{"no_idv",     ADD_R1, 0, LW5,    1, 0, 0, 0, C_NONE});
    tbl.push_back('{"no_exv",     ADD_R1, 1, LW5,    0, 0, 0, 0, C_NONE});
    tbl.push_back('{"no_exalu",   ADD_R1, 1, ADD_EX, 1, 0, 0, 0, C_NONE});
    tbl.push_back('{"mw_over_lu", ADD_R1, 1, LW5,    1, 0, 1, 0, C_MW});
    tbl.push_back('{"mw_over_rd", ADD_R1, 1, ADD_EX, 1, 1, 1, 0, C_MW});
    tbl.push_back('{"rd_over_lu", ADD_R1, 1, LW5,    1, 1, 0, 0, C_FL});
    tbl.push_back('{"zero_wait",  ADD_R1, 1, ADD_EX, 1, 0, 1, 1, C_NONE});
    tbl.push_back('{"zw_lu",      ADD_R1, 1, LW5,    1, 0, 1, 1, C_LU});
    tbl.push_back('{"ack_noreq",  ADD_R1, 1, ADD_EX, 1, 0, 0, 1, C_NONE});

    // reset state
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ctl", 32'(ctl()), 32'(C_FL));
    tick();
    chk("rst_to", 32'(mem_timeout), 0);
    chk("rst_scnt", 32'(stall_cnt), 0);
    chk("rst_fcnt", 32'(flush_cnt), 0);
    rst = 1'b0;
    #1;
    chk("idle_ctl", 32'(ctl()), 32'(C_NONE));

    foreach (tbl[i]) begin
      drive(tbl[i].idi, tbl[i].idv, tbl[i].exi, tbl[i].exv, tbl[i].rd, tbl[i].rq, tbl[i].ak);
      chk(tbl[i].nm, 32'(ctl()), 32'(tbl[i].exp));
      tick();
    end

    // load-use lasts one cycle, load then leaves EX
    do_reset();
    drive(ADD_R1, 1, LW5, 1, 0, 0, 0);
    chk("seq_lu_c0", 32'(ctl()), 32'(C_LU));
    tick();
    drive(ADD_R1, 1, 32'h0, 0, 0, 0, 0);
    chk("seq_lu_c1", 32'(ctl()), 32'(C_NONE));
    chk("seq_lu_scnt", 32'(stall_cnt), 1);
    chk("seq_lu_fcnt", 32'(flush_cnt), 1);

    // three wait cycles then ack
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, 0, 32'h0, 0, 0, 1, 0);
      chk($sformatf("mw_c%0d", i), 32'(ctl()), 32'(C_MW));
      tick();
    end
    drive(32'h0, 0, 32'h0, 0, 0, 1, 1);
    chk("mw_ack", 32'(ctl()), 32'(C_NONE));
    tick();
    drive(32'h0, 0, 32'h0, 0, 0, 0, 0);
    chk("mw_scnt", 32'(stall_cnt), 3);
    chk("mw_fcnt", 32'(flush_cnt), 0);
    chk("mw_to", 32'(mem_timeout), 0);

    // redirect with load-use, and deferred redirect after a wait
    do_reset();
    drive(ADD_R1, 1, LW5, 1, 1, 0, 0);
    chk("rd_lu_ctl", 32'(ctl()), 32'(C_FL));
    tick();
    drive(32'h0, 0, 32'h0, 0, 0, 0, 0);
    chk("rd_lu_fcnt", 32'(flush_cnt), 1);
    chk("rd_lu_scnt", 32'(stall_cnt), 0);
    drive(ADD_R1, 1, LW5, 1, 1, 1, 0);
    chk("defer_wait", 32'(ctl()), 32'(C_MW));
    tick();
    drive(ADD_R1, 1, LW5, 1, 1, 1, 1);
    chk("defer_act", 32'(ctl()), 32'(C_FL));
    tick();
    drive(32'h0, 0, 32'h0, 0, 0, 0, 0);
    chk("defer_scnt", 32'(stall_cnt), 1);
    chk("defer_fcnt", 32'(flush_cnt), 2);

    // timeout, saturation, reset mid-wait
    do_reset();
    drive(32'h0, 0, 32'h0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("to_before", 32'(mem_timeout), 0);
    tick();
    chk("to_set", 32'(mem_timeout), 1);
    for (int i = 0; i < 16; i++) tick();
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("sat_scnt", 32'(stall_cnt), 15);
    chk("sat_fcnt", 32'(flush_cnt), 0);
    rst = 1'b1;
    #1;
    chk("rstmid_ctl", 32'(ctl()), 32'(C_FL));
    tick();
    rst = 1'b0;
    drive(32'h0, 0, 32'h0, 0, 0, 0, 0);
    chk("rstmid_to", 32'(mem_timeout), 0);
    chk("rstmid_scnt", 32'(stall_cnt), 0);
    chk("rstmid_fcnt", 32'(flush_cnt), 0);
    tick();
    drive(32'h0, 0, 32'h0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("to2_before", 32'(mem_timeout), 0);
    tick();
    chk("to2_set", 32'(mem_timeout), 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
